// File: rtl/load_store_unit_pkg.sv
// Shared definitions for the load/store unit: FSM states, Funct3 access codes,
// and the alignment check used when the misaligned trap is built in.
// Pure types/constants/functions; no latency or flow control of its own.
package load_store_unit_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } lsu_state_t;

    // Funct3 load/store encodings (RISC-V style)
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // Access size lives in Funct3[1:0]; 2'b1x is handled as a word.
    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;

    // Half must sit on an even byte, word on a word boundary.
    function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] a);
        logic mis;
        mis = 1'b0;
        if (f3[1:0] == SZ_H)
            mis = a[0];
        else if (f3[1:0] != SZ_B)
            mis = (a != 2'b00);
        return mis;
    endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Load alignment: picks the addressed byte/half from the bus word and extends it.
// Latency: purely combinational. Backpressure: none, no state.
// Ports: rdata (bus word), addr_lo (byte offset), funct3 (size/extension), data (result).
module lsu_load_align
    import load_store_unit_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  addr_lo,
    input  logic [2:0]  funct3,
    output logic [31:0] data
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = rdata[7:0];
        case (addr_lo)
            2'd0: byte_sel = rdata[7:0];
            2'd1: byte_sel = rdata[15:8];
            2'd2: byte_sel = rdata[23:16];
            2'd3: byte_sel = rdata[31:24];
            default: byte_sel = rdata[7:0];
        endcase
        half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];

        data = rdata;
        case (funct3)
            F3_B:    data = {{24{byte_sel[7]}}, byte_sel};
            F3_H:    data = {{16{half_sel[15]}}, half_sel};
            F3_BU:   data = {24'd0, byte_sel};
            F3_HU:   data = {16'd0, half_sel};
            default: data = rdata;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: turns a held MemReq into one req/gnt(/rvalid) bus transaction.
// Latency: store done 2 cycles after MemReq, load 3 (zero-wait bus); timeout -> BusErr.
// Backpressure: LSU_Stall holds the pipeline until the single-cycle LSU_Done pulse.
// Ports: MemReq/MemWrite/Funct3/ALUResult/WriteData from the pipe; dmem_* bus master;
//        ReadData (registered load result), LSU_Stall, LSU_Done, BusErr, Misaligned.
// Build option: define LSU_MISALIGN_TRAP_EN to complete misaligned accesses without a
// bus cycle and flag Misaligned; otherwise low address bits are simply dropped.
module load_store_unit
    import load_store_unit_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        MemReq,
    input  logic        MemWrite,
    input  logic [2:0]  Funct3,
    input  logic [31:0] ALUResult,
    input  logic [31:0] WriteData,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [3:0]  dmem_be,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_gnt,
    input  logic        dmem_rvalid,
    input  logic [31:0] dmem_rdata,
    output logic [31:0] ReadData,
    output logic        LSU_Stall,
    output logic        LSU_Done,
    output logic        BusErr,
    output logic        Misaligned
);

    localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
    // Counter reads 0 in the first REQ cycle, so the last allowed cycle is N-1.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    lsu_state_t       state, next_state;
    logic [CNT_W-1:0] cnt;
    logic             timeout;
    logic             to_err;
    logic [31:0]      load_data;

    assign timeout = (cnt == CNT_LAST);

    // Bus-side fields come straight from the pipeline inputs, which the
    // pipeline keeps stable while LSU_Stall is high.
    assign dmem_req  = (state == REQ);
    assign dmem_we   = (state == REQ) & MemWrite;
    assign dmem_addr = {ALUResult[31:2], 2'b00};

    always_comb begin
        dmem_be    = 4'b1111;
        dmem_wdata = WriteData;
        case (Funct3[1:0])
            SZ_B: begin
                dmem_be    = 4'b0001 << ALUResult[1:0];
                dmem_wdata = {4{WriteData[7:0]}};
            end
            SZ_H: begin
                dmem_be    = ALUResult[1] ? 4'b1100 : 4'b0011;
                dmem_wdata = {2{WriteData[15:0]}};
            end
            default: begin
                dmem_be    = 4'b1111;
                dmem_wdata = WriteData;
            end
        endcase
    end

    lsu_load_align u_align (
        .rdata   (dmem_rdata),
        .addr_lo (ALUResult[1:0]),
        .funct3  (Funct3),
        .data    (load_data)
    );

`ifdef LSU_MISALIGN_TRAP_EN
    logic trap;
    logic mis_q;
`endif

    // Next state. A bus event in the same cycle as the timeout takes priority.
    always_comb begin
        next_state = state;
        to_err     = 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
        trap       = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (MemReq) begin
`ifdef LSU_MISALIGN_TRAP_EN
                    if (is_misaligned(Funct3, ALUResult[1:0])) begin
                        next_state = DONE;
                        trap       = 1'b1;
                    end else begin
                        next_state = REQ;
                    end
`else
                    next_state = REQ;
`endif
                end
            end
            REQ: begin
                if (dmem_gnt) begin
                    next_state = MemWrite ? DONE : WAIT;
                end else if (timeout) begin
                    next_state = DONE;
                    to_err     = 1'b1;
                end
            end
            WAIT: begin
                if (dmem_rvalid) begin
                    next_state = DONE;
                end else if (timeout) begin
                    next_state = DONE;
                    to_err     = 1'b1;
                end
            end
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            cnt      <= '0;
            BusErr   <= 1'b0;
            ReadData <= 32'd0;
        end else begin
            state <= next_state;
            if (state == IDLE && next_state == REQ)
                cnt <= '0;
            else if (state == REQ || state == WAIT)
                cnt <= cnt + CNT_W'(1);
            // Flag registered on entry to DONE, so it is high only with LSU_Done.
            BusErr <= to_err;
            if (state == WAIT && dmem_rvalid)
                ReadData <= load_data;
            else if (to_err && !MemWrite)
                ReadData <= 32'd0;
        end
    end

`ifdef LSU_MISALIGN_TRAP_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            mis_q <= 1'b0;
        else
            mis_q <= trap;
    end
    assign Misaligned = mis_q;
`else
    assign Misaligned = 1'b0;
`endif

    assign LSU_Done  = (state == DONE);
    assign LSU_Stall = ((state == IDLE) & MemReq) | (state == REQ) | (state == WAIT);

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit (TIMEOUT_CYCLES=4): loads/stores of each
// size, timeout with and without a coinciding grant, misaligned word, and reset
// during an outstanding load.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        MemReq, MemWrite;
    logic [2:0]  Funct3;
    logic [31:0] ALUResult, WriteData;
    logic        dmem_req, dmem_we;
    logic [31:0] dmem_addr, dmem_wdata;
    logic [3:0]  dmem_be;
    logic        dmem_gnt, dmem_rvalid;
    logic [31:0] dmem_rdata;
    logic [31:0] ReadData;
    logic        LSU_Stall, LSU_Done, BusErr, Misaligned;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    load_store_unit #(.TIMEOUT_CYCLES(4)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .MemReq      (MemReq),
        .MemWrite    (MemWrite),
        .Funct3      (Funct3),
        .ALUResult   (ALUResult),
        .WriteData   (WriteData),
        .dmem_req    (dmem_req),
        .dmem_we     (dmem_we),
        .dmem_addr   (dmem_addr),
        .dmem_be     (dmem_be),
        .dmem_wdata  (dmem_wdata),
        .dmem_gnt    (dmem_gnt),
        .dmem_rvalid (dmem_rvalid),
        .dmem_rdata  (dmem_rdata),
        .ReadData    (ReadData),
        .LSU_Stall   (LSU_Stall),
        .LSU_Done    (LSU_Done),
        .BusErr      (BusErr),
        .Misaligned  (Misaligned)
    );

    task automatic chk(input string tag, input logic ok, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        if (ok !== 1'b1) begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_load(input string tag, input logic [31:0] addr, input logic [2:0] f3,
                           input logic [31:0] rd, input logic [3:0] exp_be,
                           input logic [31:0] exp_data);
        MemReq = 1'b1; MemWrite = 1'b0; Funct3 = f3; ALUResult = addr;
        #1;
        chk({tag, " idle_stall"}, LSU_Stall === 1'b1, LSU_Stall, 1'b1);
        chk({tag, " idle_req"}, dmem_req === 1'b0, dmem_req, 1'b0);
        tick();
        chk({tag, " req"}, dmem_req === 1'b1, dmem_req, 1'b1);
        chk({tag, " we"}, dmem_we === 1'b0, dmem_we, 1'b0);
        chk({tag, " addr"}, dmem_addr === {addr[31:2], 2'b00}, dmem_addr, {addr[31:2], 2'b00});
        chk({tag, " be"}, dmem_be === exp_be, dmem_be, exp_be);
        dmem_gnt = 1'b1;
        tick();
        dmem_gnt = 1'b0;
        #1;
        chk({tag, " wait_req"}, dmem_req === 1'b0, dmem_req, 1'b0);
        chk({tag, " wait_stall"}, LSU_Stall === 1'b1, LSU_Stall, 1'b1);
        chk({tag, " wait_done"}, LSU_Done === 1'b0, LSU_Done, 1'b0);
        dmem_rvalid = 1'b1; dmem_rdata = rd;
        tick();
        dmem_rvalid = 1'b0; dmem_rdata = 32'hA5A5_A5A5;
        #1;
        chk({tag, " done"}, LSU_Done === 1'b1, LSU_Done, 1'b1);
        chk({tag, " data"}, ReadData === exp_data, ReadData, exp_data);
        chk({tag, " buserr"}, BusErr === 1'b0, BusErr, 1'b0);
        chk({tag, " mis"}, Misaligned === 1'b0, Misaligned, 1'b0);
        chk({tag, " done_stall"}, LSU_Stall === 1'b0, LSU_Stall, 1'b0);
        MemReq = 1'b0;
        tick();
        chk({tag, " idle_done"}, LSU_Done === 1'b0, LSU_Done, 1'b0);
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog expired observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; MemReq = 1'b0; MemWrite = 1'b0; Funct3 = 3'b000;
        ALUResult = 32'd0; WriteData = 32'd0;
        dmem_gnt = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = 32'd0;
        #12;
        chk("rst req", dmem_req === 1'b0, dmem_req, 1'b0);
        chk("rst done", LSU_Done === 1'b0, LSU_Done, 1'b0);
        chk("rst stall", LSU_Stall === 1'b0, LSU_Stall, 1'b0);
        chk("rst rdata", ReadData === 32'd0, ReadData, 32'd0);
        chk("rst buserr", BusErr === 1'b0, BusErr, 1'b0);
        chk("rst mis", Misaligned === 1'b0, Misaligned, 1'b0);
        rst_n = 1'b1;
        tick();

        do_load("lb",  32'h0000_1003, 3'b000, 32'h80FF_0000, 4'b1000, 32'hFFFF_FF80);
        do_load("lbu", 32'h0000_1003, 3'b100, 32'h80FF_0000, 4'b1000, 32'h0000_0080);

        MemReq = 1'b1; MemWrite = 1'b1; Funct3 = 3'b001;
        ALUResult = 32'h0000_2002; WriteData = 32'h1234_ABCD;
        tick();
        chk("sh req", dmem_req === 1'b1, dmem_req, 1'b1);
        chk("sh we", dmem_we === 1'b1, dmem_we, 1'b1);
        chk("sh addr", dmem_addr === 32'h0000_2000, dmem_addr, 32'h0000_2000);
        chk("sh be", dmem_be === 4'b1100, dmem_be, 4'b1100);
        chk("sh wdata", dmem_wdata === 32'hABCD_ABCD, dmem_wdata, 32'hABCD_ABCD);
        chk("sh cyc1_done", LSU_Done === 1'b0, LSU_Done, 1'b0);
        dmem_gnt = 1'b1;
        tick();
        dmem_gnt = 1'b0;
        #1;
        chk("sh cyc2_done", LSU_Done === 1'b1, LSU_Done, 1'b1);
        chk("sh rdata_kept", ReadData === 32'h0000_0080, ReadData, 32'h0000_0080);
        chk("sh buserr", BusErr === 1'b0, BusErr, 1'b0);
        MemReq = 1'b0; MemWrite = 1'b0;
        tick();

        do_load("lb+", 32'h0000_1001, 3'b000, 32'h0000_7F00, 4'b0010, 32'h0000_007F);
        do_load("lh",  32'h0000_2002, 3'b001, 32'hBEEF_1234, 4'b1100, 32'hFFFF_BEEF);
        do_load("lhu", 32'h0000_2002, 3'b101, 32'hBEEF_1234, 4'b1100, 32'h0000_BEEF);
        do_load("lh0", 32'h0000_2000, 3'b001, 32'h0000_8001, 4'b0011, 32'hFFFF_8001);

        MemReq = 1'b1; MemWrite = 1'b0; Funct3 = 3'b010; ALUResult = 32'h0000_5000;
        tick();
        for (int i = 0; i < 4; i++) begin
            chk("to req_held", dmem_req === 1'b1, dmem_req, 1'b1);
            chk("to no_done", LSU_Done === 1'b0, LSU_Done, 1'b0);
            tick();
        end
        chk("to done", LSU_Done === 1'b1, LSU_Done, 1'b1);
        chk("to buserr", BusErr === 1'b1, BusErr, 1'b1);
        chk("to rdata_zero", ReadData === 32'd0, ReadData, 32'd0);
        chk("to req_drop", dmem_req === 1'b0, dmem_req, 1'b0);
        MemReq = 1'b0;
        tick();
        chk("to buserr_clr", BusErr === 1'b0, BusErr, 1'b0);

        MemReq = 1'b1; MemWrite = 1'b1; Funct3 = 3'b000;
        ALUResult = 32'h0000_6001; WriteData = 32'h0000_0055;
        tick();
        chk("co be", dmem_be === 4'b0010, dmem_be, 4'b0010);
        chk("co wdata", dmem_wdata === 32'h5555_5555, dmem_wdata, 32'h5555_5555);
        tick();
        tick();
        tick();
        dmem_gnt = 1'b1;
        #1;
        chk("co req4", dmem_req === 1'b1, dmem_req, 1'b1);
        tick();
        dmem_gnt = 1'b0;
        #1;
        chk("co done", LSU_Done === 1'b1, LSU_Done, 1'b1);
        chk("co buserr", BusErr === 1'b0, BusErr, 1'b0);
        MemReq = 1'b0; MemWrite = 1'b0;
        tick();

        do_load("lw", 32'h0000_4000, 3'b010, 32'hCAFE_F00D, 4'b1111, 32'hCAFE_F00D);

`ifdef LSU_MISALIGN_TRAP_EN
        MemReq = 1'b1; MemWrite = 1'b0; Funct3 = 3'b010; ALUResult = 32'h0000_3001;
        #1;
        chk("mis idle_req", dmem_req === 1'b0, dmem_req, 1'b0);
        tick();
        chk("mis done", LSU_Done === 1'b1, LSU_Done, 1'b1);
        chk("mis flag", Misaligned === 1'b1, Misaligned, 1'b1);
        chk("mis req", dmem_req === 1'b0, dmem_req, 1'b0);
        chk("mis rdata_kept", ReadData === 32'hCAFE_F00D, ReadData, 32'hCAFE_F00D);
        chk("mis buserr", BusErr === 1'b0, BusErr, 1'b0);
        MemReq = 1'b0;
        tick();
        chk("mis flag_clr", Misaligned === 1'b0, Misaligned, 1'b0);
        chk("mis done_clr", LSU_Done === 1'b0, LSU_Done, 1'b0);
`else
        do_load("lw_mis", 32'h0000_3001, 3'b010, 32'h1122_3344, 4'b1111, 32'h1122_3344);
`endif

        MemReq = 1'b1; MemWrite = 1'b0; Funct3 = 3'b010; ALUResult = 32'h0000_7000;
        tick();
        dmem_gnt = 1'b1;
        tick();
        dmem_gnt = 1'b0;
        #1;
        chk("rmid wait_stall", LSU_Stall === 1'b1, LSU_Stall, 1'b1);
        rst_n = 1'b0; MemReq = 1'b0;
        #1;
        chk("rmid req", dmem_req === 1'b0, dmem_req, 1'b0);
        chk("rmid stall", LSU_Stall === 1'b0, LSU_Stall, 1'b0);
        chk("rmid done", LSU_Done === 1'b0, LSU_Done, 1'b0);
        chk("rmid rdata", ReadData === 32'd0, ReadData, 32'd0);
        dmem_rvalid = 1'b1; dmem_rdata = 32'hDEAD_BEEF;
        tick();
        rst_n = 1'b1;
        tick();
        dmem_rvalid = 1'b0;
        #1;
        chk("rpost done", LSU_Done === 1'b0, LSU_Done, 1'b0);
        chk("rpost rdata", ReadData === 32'd0, ReadData, 32'd0);
        chk("rpost stall", LSU_Stall === 1'b0, LSU_Stall, 1'b0);
        chk("rpost req", dmem_req === 1'b0, dmem_req, 1'b0);
        tick();
        chk("rpost2 done", LSU_Done === 1'b0, LSU_Done, 1'b0);
        chk("rpost2 rdata", ReadData === 32'd0, ReadData, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 The block SHALL have parameter TIMEOUT_CYCLES, default 255, giving the maximum number of cycles spent waiting on the bus before a bus error.
REQ-002 The block SHALL have these ports, clock and reset first:
- clk  in  1  the single clock; all state changes on its rising edge.
- rst_n  in  1  reset; asynchronous, active-low.
- MemReq  in  1  a memory operation is requested; held until LSU_Done.
- MemWrite  in  1  1 = store, 0 = load.
- Funct3  in  3  access size and sign-extension code.
- ALUResult  in  32  byte address.
- WriteData  in  32  store data, in the low lanes.
- dmem_req  out  1  bus request.
- dmem_we  out  1  bus write enable.
- dmem_addr  out  32  word-aligned bus address.
- dmem_be  out  4  byte enables.
- dmem_wdata  out  32  lane-replicated store data.
- dmem_gnt  in  1  bus accepted the request.
- dmem_rvalid  in  1  load data valid.
- dmem_rdata  in  32  load data.
- ReadData  out  32  registered, extended load result; feeds the writeback result select.
- LSU_Stall  out  1  pipeline must hold.
- LSU_Done  out  1  one-cycle completion pulse.
- BusErr  out  1  the completed operation timed out.
- Misaligned  out  1  the completed operation was misaligned.

Function
REQ-003 The FSM SHALL have four states, IDLE, REQ, WAIT and DONE, with these transitions:
- IDLE to REQ when MemReq=1.
- REQ to DONE on dmem_gnt for a store.
- REQ to WAIT on dmem_gnt for a load.
- WAIT to DONE on dmem_rvalid.
- DONE to IDLE unconditionally.
REQ-004 In REQ, dmem_req SHALL be 1, and dmem_we/addr/be/wdata SHALL be held stable until dmem_gnt; in all other states dmem_req SHALL be 0.
REQ-005 dmem_addr SHALL equal {ALUResult[31:2],2'b00}.
REQ-006 Byte enables SHALL be set by Funct3:
- 000 (byte): one-hot at addr[1:0].
- 001 (half): 0011 or 1100, selected by addr[1].
- 010 (word): 1111.
- Other values: treated as word.
REQ-007 Store data SHALL be replicated to all lanes: the byte x4, or the half x2.
REQ-008 On dmem_rvalid in WAIT, ReadData SHALL be loaded with the selected lane, extended per Funct3:
- 000 sign-extended byte.
- 001 sign-extended half.
- 010 word.
- 100 zero-extended byte.
- 101 zero-extended half.
REQ-009 ReadData SHALL otherwise hold its value; on a store it SHALL be unchanged.
REQ-010 LSU_Stall SHALL be combinational: 1 when (IDLE and MemReq) or in REQ or in WAIT, and 0 in DONE.
REQ-011 LSU_Done SHALL be 1 exactly in DONE; BusErr and Misaligned SHALL be valid only while LSU_Done=1, and 0 otherwise.
REQ-012 Minimum latency SHALL be:
- Store with gnt in the first REQ cycle: LSU_Done 2 cycles after MemReq is sampled.
- Load with gnt and then rvalid on the next cycle: 3 cycles.
REQ-013 Timeout SHALL work as follows:
- An 8-bit-minimum counter clears on entry to REQ and increments each cycle in REQ or WAIT.
- At TIMEOUT_CYCLES it SHALL force DONE with BusErr=1; ReadData is set to 0 for a load.
- If gnt or rvalid coincides with the timeout, the bus event SHALL win and BusErr=0.
REQ-014 dmem_rvalid outside WAIT and dmem_gnt outside REQ SHALL be ignored.

Reset
REQ-015 Asserting rst_n low SHALL, asynchronously and at any state (including mid-transaction):
- Set the state to IDLE.
- Set ReadData, the counter, BusErr and Misaligned to 0.
- Make dmem_req, LSU_Done and LSU_Stall (MemReq=0) all 0.
No pending bus response SHALL be honoured after reset.

Configuration
REQ-016 The macro LSU_MISALIGN_TRAP_EN SHALL select misaligned-access handling.
- Defined: a half access with addr[0]=1, or a word access with addr[1:0]!=0, SHALL go IDLE to DONE with no bus request, Misaligned=1 and ReadData unchanged.
- Undefined: low address bits are ignored for alignment (half uses addr[1], word uses the whole word), and Misaligned is tied to 0.

Structure
REQ-017 A shared package SHALL hold the FSM state enum and the Funct3 load/store encodings.
REQ-018 Lane selection and extension SHALL be a combinational sub-module, lsu_load_align.

Verification
REQ-019 The bench SHALL cover these directed scenarios:
- Load-byte: LB at 0x1003 with rdata 0x80FF_0000 -> dmem_be=1000, ReadData=0xFFFF_FF80; LBU gives 0x0000_0080.
- Store-half: SH at 0x2002 with WriteData 0x1234_ABCD, gnt in first REQ -> dmem_be=1100, dmem_wdata=0xABCD_ABCD, LSU_Done on cycle 2.
- Timeout: TIMEOUT_CYCLES=4, gnt never asserted -> LSU_Done with BusErr=1 after 4 REQ cycles.
- Misaligned word: LW at 0x3001 -> with the macro, Misaligned=1 and dmem_req never asserted; without it, dmem_addr=0x3000 and normal completion.
- Reset mid-transaction: rst_n low during WAIT, then rvalid arrives -> state IDLE, ReadData=0, no LSU_Done.
